ahb2apb_bridge_v2: RTL and testbench

Single-clock AHB-Lite to APB4 bridge with full APB SETUP/ACCESS sequencing, parametrised slave count and widths, per-slave PREADY wait states and PSLVERR-to-AHB ERROR mapping. It sits between the AHB interconnect and the peripheral APB segment (UART, SPI, I2C, memory, LED, ...). Decode errors and slave errors are returned as a two-cycle AHB ERROR response.

---
 rtl/ahb2apb_bridge_v2.sv | 209 ++++++++++++++++++++
 tb/tb_ahb2apb_bridge_v2.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge_v2.sv
// ahb2apb_bridge_v2 - single-clock AHB-Lite to APB4 bridge.
//
// Converts one AHB-Lite transfer at a time into an APB SETUP/ACCESS
// sequence towards one of SLV_NUM slaves. The slave is selected by
// haddr[PADDR_WIDTH +: SEL_W]. Decode errors (idx >= SLV_NUM) and slave
// errors (PSLVERR) come back as a two-cycle AHB ERROR response.
//
// Optional build macro: AHB2APB_TIMEOUT_EN
//   Defined   - ACCESS is aborted with an ERROR response once the selected
//               slave has held pready low for TIMEOUT_CYCLES cycles.
//   Undefined - ACCESS waits for pready indefinitely.
//
// Ports
//   hclk, hreset            clock, synchronous active-high reset
//   haddr, htrans, hwrite,  AHB address phase
//   hsize, hsel, hready_i
//   hwdata, hwstrb          AHB write data phase
//   hready_o, hresp_o,      AHB response
//   hrdata_o
//   paddr, psel, penable,   APB request (psel is one-hot)
//   pwrite, pwdata, pstrb
//   pready_i, pslverr_i,    APB per-slave response, prdata_i is flattened:
//   prdata_i                slave k at [k*DATA_WIDTH +: DATA_WIDTH]
//
// state  | meaning
// IDLE   | waiting for an accepted transfer, hready_o=1
// WDATA  | write accepted, capture AHB write data and strobes
// SETUP  | APB setup phase, psel high, penable low
// ACCESS | APB access phase, waiting for the slave's pready
// RESP   | OKAY completion, hready_o=1, may accept the next transfer
// ERR1   | first ERROR cycle, hready_o=0
// ERR2   | second ERROR cycle, hready_o=1, nothing accepted here

module ahb2apb_bridge_v2 #(
  parameter int HADDR_WIDTH    = 32,
  parameter int PADDR_WIDTH    = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int SLV_NUM        = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [HADDR_WIDTH-1:0]           haddr,
  input  logic [1:0]                       htrans,
  input  logic                             hwrite,
  input  logic [2:0]                       hsize,
  input  logic [DATA_WIDTH-1:0]            hwdata,
  input  logic [DATA_WIDTH/8-1:0]          hwstrb,
  input  logic                             hsel,
  input  logic                             hready_i,
  output logic                             hready_o,
  output logic                             hresp_o,
  output logic [DATA_WIDTH-1:0]            hrdata_o,
  output logic [PADDR_WIDTH-1:0]           paddr,
  output logic [SLV_NUM-1:0]               psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [SLV_NUM-1:0]               pready_i,
  input  logic [SLV_NUM-1:0]               pslverr_i,
  input  logic [SLV_NUM*DATA_WIDTH-1:0]    prdata_i
);

  localparam int SEL_W  = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_ERR1   = 3'd5;
  localparam logic [2:0] S_ERR2   = 3'd6;

  logic [2:0]             state;
  logic [HADDR_WIDTH-1:0] haddr_q;
  logic [2:0]             hsize_q;
  logic                   hwrite_q;
  logic [SEL_W-1:0]       idx;

  logic                   accept;
  logic [SEL_W-1:0]       idx_in;
  logic                   dec_err_in;
  logic [SEL_W-1:0]       setup_idx;
  logic [SLV_NUM-1:0]     setup_onehot;
  logic                   sel_ready;
  logic                   sel_err;
  logic [DATA_WIDTH-1:0]  sel_rdata;

`ifdef AHB2APB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_comb begin
    hready_o = (state == S_IDLE) || (state == S_RESP) || (state == S_ERR2);
    hresp_o  = (state == S_ERR1) || (state == S_ERR2);
  end

  // ERR2 shows hready_o=1 but the master is obliged to cancel, so it is
  // excluded from acceptance explicitly.
  assign accept     = hsel & hready_i & htrans[1] & hready_o & (state != S_ERR2);
  assign idx_in     = haddr[PADDR_WIDTH +: SEL_W];
  assign dec_err_in = (32'(idx_in) >= 32'(SLV_NUM));

  // Reads enter SETUP straight from the accept edge, before idx is registered.
  assign setup_idx = (state == S_WDATA) ? idx : idx_in;

  always_comb begin
    setup_onehot = '0;
    sel_ready    = 1'b0;
    sel_err      = 1'b0;
    sel_rdata    = '0;
    for (int k = 0; k < SLV_NUM; k++) begin
      if (32'(setup_idx) == k) setup_onehot[k] = 1'b1;
      if (32'(idx) == k) begin
        sel_ready = pready_i[k];
        sel_err   = pslverr_i[k];
        sel_rdata = prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= S_IDLE;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      idx      <= '0;
      hrdata_o <= '0;
      paddr    <= '0;
      psel     <= '0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      pstrb    <= '0;
`ifdef AHB2APB_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            haddr_q  <= haddr;
            hsize_q  <= hsize;
            hwrite_q <= hwrite;
            idx      <= idx_in;
            if (dec_err_in) begin
              state <= S_ERR1;
            end else if (hwrite) begin
              state <= S_WDATA;
            end else begin
              state  <= S_SETUP;
              paddr  <= haddr[PADDR_WIDTH-1:0];
              pwrite <= 1'b0;
              pstrb  <= '0;
              psel   <= setup_onehot;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WDATA: begin
          state  <= S_SETUP;
          paddr  <= haddr_q[PADDR_WIDTH-1:0];
          pwrite <= 1'b1;
          pwdata <= hwdata;
          pstrb  <= hwstrb;
          psel   <= setup_onehot;
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
`ifdef AHB2APB_TIMEOUT_EN
          tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_ACCESS: begin
          // A ready in the last allowed cycle still completes normally.
          if (sel_ready) begin
            psel    <= '0;
            penable <= 1'b0;
            if (sel_err) begin
              state <= S_ERR1;
            end else begin
              state <= S_RESP;
              if (!hwrite_q) hrdata_o <= sel_rdata;
            end
          end
`ifdef AHB2APB_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= S_ERR1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        S_ERR1:  state <= S_ERR2;
        S_ERR2:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge_v2.sv
module tb_ahb2apb_bridge_v2;

  localparam int HAW = 32;
  localparam int PAW = 16;
  localparam int DW  = 32;
  localparam int NS  = 5;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            hreset;
  logic [HAW-1:0]  haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [DW-1:0]   hwdata;
  logic [DW/8-1:0] hwstrb;
  logic            hsel;
  logic            hready_i;
  logic            hready_o;
  logic            hresp_o;
  logic [DW-1:0]   hrdata_o;
  logic [PAW-1:0]  paddr;
  logic [NS-1:0]   psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [NS-1:0]   pready_i;
  logic [NS-1:0]   pslverr_i;
  logic [NS*DW-1:0] prdata_i;

  always #5 clk = ~clk;

  ahb2apb_bridge_v2 #(
    .HADDR_WIDTH(HAW), .PADDR_WIDTH(PAW), .DATA_WIDTH(DW),
    .SLV_NUM(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .hclk(clk), .hreset(hreset), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb),
    .hsel(hsel), .hready_i(hready_i), .hready_o(hready_o),
    .hresp_o(hresp_o), .hrdata_o(hrdata_o), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model of the values the bridge should be holding
  logic [DW-1:0] last_rdata;
  logic [DW-1:0] last_pwdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One AHB transfer, entered and left at a negedge. On entry the bridge
  // must be able to accept (IDLE or RESP). Returns with the bridge in its
  // final response cycle (RESP or ERR2). The expected timeline is derived
  // from the protocol: write data phase (writes only), one SETUP cycle,
  // waits+1 ACCESS cycles, then OKAY or a two-cycle ERROR.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] rdata,
                      input int waits, input bit serr, output bit err);
    int idx, s, alen, last, acc_seen;
    bit derr, tmo, in_setup, in_acc, exp_rdy, exp_resp;
    logic [NS-1:0] exp_psel;
    logic [DW-1:0] exp_hrdata;
    idx  = int'(addr[PAW +: 3]);
    derr = (idx >= NS);
    s    = wr ? 2 : 1;
    alen = waits + 1;
    tmo  = 1'b0;
`ifdef AHB2APB_TIMEOUT_EN
    if (alen > TO) begin
      alen = TO;
      tmo  = 1'b1;
    end
`endif
    err        = derr | serr | tmo;
    last       = derr ? 2 : (s + alen + (err ? 2 : 1));
    exp_hrdata = (!wr && !err) ? rdata : last_rdata;
    acc_seen   = 0;

    hsel     = 1'b1;
    htrans   = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
    haddr    = addr;
    hwrite   = wr;
    hsize    = 3'd2;
    hready_i = 1'b1;

    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        hsel   = 1'($urandom);
        htrans = 2'b00;
        haddr  = $urandom;
        hwrite = 1'($urandom);
        hwdata = wdata;
        hwstrb = strb;
      end
      if (derr) begin
        exp_rdy  = (k == 2);
        exp_resp = 1'b1;
      end else if (k <= s + alen) begin
        exp_rdy  = 1'b0;
        exp_resp = 1'b0;
      end else if (k == s + alen + 1) begin
        exp_rdy  = !err;
        exp_resp = err;
      end else begin
        exp_rdy  = 1'b1;
        exp_resp = 1'b1;
      end
      chk("hready_hresp", 64'({hready_o, hresp_o}), 64'({exp_rdy, exp_resp}));
      in_setup = !derr && (k == s);
      in_acc   = !derr && (k > s) && (k <= s + alen);
      exp_psel = (in_setup || in_acc) ? NS'(1 << idx) : '0;
      chk("psel_penable", 64'({psel, penable}), 64'({exp_psel, in_acc}));
      if (in_setup || in_acc)
        chk("apb_fields", 64'({paddr, pwrite, pwdata, pstrb}),
            64'({addr[PAW-1:0], wr, (wr ? wdata : last_pwdata), (wr ? strb : 4'h0)}));
      if (k == last) chk("hrdata", 64'(hrdata_o), 64'(exp_hrdata));

      // slave side: other slaves get random responses, the target one
      // answers after 'waits' ACCESS cycles observed on the DUT outputs
      pready_i  = NS'($urandom);
      pslverr_i = NS'($urandom);
      for (int j = 0; j < NS; j++) prdata_i[j*DW +: DW] = $urandom;
      if (!derr) begin
        prdata_i[idx*DW +: DW] = rdata;
        pslverr_i[idx]         = serr;
        if (psel[idx] && penable) begin
          acc_seen++;
          pready_i[idx] = (acc_seen >= waits + 1);
        end else begin
          pready_i[idx] = 1'($urandom);
        end
      end
    end
    last_rdata = exp_hrdata;
    if (wr && !derr) last_pwdata = wdata;
  endtask

  // A non-accepted bus cycle: hsel low, IDLE/BUSY, or hready_i low.
  task automatic idle_cycle();
    case ($urandom_range(0, 2))
      0: begin hsel = 1'b0; htrans = 2'b10; hready_i = 1'b1; end
      1: begin hsel = 1'b1; htrans = 2'($urandom_range(0, 1)); hready_i = 1'b1; end
      default: begin hsel = 1'b1; htrans = 2'b10; hready_i = 1'b0; end
    endcase
    haddr = $urandom;
    @(negedge clk);
    chk("idle_resp", 64'({hready_o, hresp_o}), 64'(2'b10));
    chk("idle_apb", 64'({psel, penable}), 64'(0));
    hready_i = 1'b1;
  endtask

  initial begin
    bit err, wr, serr, b2b;
    int widx, waits;
    logic [31:0] a;

    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
    hsize = 3'd0; hwdata = '0; hwstrb = '0; hready_i = 1'b1;
    pready_i = '0; pslverr_i = '0; prdata_i = '0;
    last_rdata = '0; last_pwdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({hready_o, hresp_o, psel, penable, pwrite, pstrb}), 64'({2'b10, 11'd0}));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_pwdata", 64'(pwdata), 64'(0));
    chk("rst_hrdata", 64'(hrdata_o), 64'(0));
    hreset = 1'b0;

    // directed cases
    xfer(1'b1, 32'h4001_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1'b0, err);
    chk("wr_zero_wait_ok", 64'(err), 64'(0));
    idle_cycle();
    xfer(1'b0, 32'h4003_0010, 32'h0, 4'h0, 32'h1234_5678, 3, 1'b0, err);
    idle_cycle();
    xfer(1'b1, 32'h4002_0008, 32'hA5A5_0001, 4'h3, 32'h0, 0, 1'b1, err);
    idle_cycle();
    xfer(1'b0, 32'h4007_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 1'b0, err);
    idle_cycle();
    xfer(1'b0, 32'h4000_0100, 32'h0, 4'h0, 32'h0BAD_CAFE, 0, 1'b0, err);
    xfer(1'b0, 32'h4004_0204, 32'h0, 4'h0, 32'h7777_1111, 1, 1'b0, err);
    xfer(1'b1, 32'h4001_0300, 32'h0102_0304, 4'h9, 32'h0, 2, 1'b0, err);
    idle_cycle();

`ifdef AHB2APB_TIMEOUT_EN
    xfer(1'b0, 32'h4000_0040, 32'h0, 4'h0, 32'h1111_2222, 1000, 1'b0, err);
    chk("timeout_err", 64'(err), 64'(1));
    idle_cycle();
`endif

    // reset during ACCESS drops the APB transfer
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4004_0020; hwrite = 1'b0; hready_i = 1'b1;
    @(negedge clk);
    htrans = 2'b00; pready_i = '0;
    @(negedge clk);
    chk("pre_rst_access", 64'({psel, penable}), 64'({5'b10000, 1'b1}));
    hreset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctrl", 64'({hready_o, hresp_o, psel, penable, pwrite, pstrb}), 64'({2'b10, 11'd0}));
    chk("mid_rst_data", 64'({paddr, pwdata}), 64'(0));
    chk("mid_rst_hrdata", 64'(hrdata_o), 64'(0));
    hreset = 1'b0;
    last_rdata = '0; last_pwdata = '0;
    idle_cycle();

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      wr    = 1'($urandom);
      widx  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NS-1) : $urandom_range(NS, 7);
      waits = $urandom_range(0, 4);
      serr  = ($urandom_range(0, 5) == 0);
      a     = {16'h4000, 16'h0} | (32'(widx) << PAW) | {16'h0, 14'($urandom), 2'b00};
      xfer(wr, a, $urandom, 4'($urandom), $urandom, waits, serr, err);
      b2b = 1'($urandom);
      if (err || !b2b) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
